pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the MIPS datapath fetch stage. It holds the current fetch address and selects the next one from several sources: sequential increment, branch/jump redirect, return-address-stack pop, and exception vector. It also keeps an exception PC (EPC) and a small circular return-address stack (RAS). It feeds the instruction memory address port and is stalled by the hazard unit.

---
 rtl/pc_pkg.sv | 16 +
 rtl/ras_stack.sv | 50 +++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
// Holds the next-PC source encoding and default vector constants.
package pc_pkg;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_REDIRECT,
    SRC_RETURN,
    SRC_EXC
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;
  localparam int          DEF_INC       = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest.
// Pointer addresses the next free slot, so the top is one below it.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  localparam int PTR_W    = $clog2(RAS_DEPTH),
  localparam int CNT_W    = $clog2(RAS_DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Push,
  input  logic              Pop,
  input  logic [ADDR_W-1:0] PushData,
  output logic [ADDR_W-1:0] Top,
  output logic [CNT_W-1:0]  Count,
  output logic              Empty,
  output logic              Full
);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_idx;

  assign top_idx = ptr - PTR_W'(1);
  assign Top     = mem[top_idx];
  assign Empty   = (Count == '0);
  assign Full    = (Count == CNT_W'(RAS_DEPTH));

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge Clk) begin
    if (Push)
      mem[ptr] <= PushData;
  end

  // Pointer and occupancy; pop is ignored when empty.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr   <= '0;
      Count <= '0;
    end else if (Push) begin
      ptr <= ptr + PTR_W'(1);
      if (!Full)
        Count <= Count + CNT_W'(1);
    end else if (Pop && !Empty) begin
      ptr   <= top_idx;
      Count <= Count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC mux, PC/EPC registers and RAS.
// Define PC_TRACE_EN to print a per-cycle PC/EPC/RAS trace in simulation.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
  parameter int                INC       = DEF_INC,
  parameter int                RAS_DEPTH = 4,
  localparam int               CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              PCWrite,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectTarget,
  input  logic              Call,
  input  logic              Return,
  input  logic              Exception,
  output logic [ADDR_W-1:0] PCResult,
  output logic [ADDR_W-1:0] EPC,
  output logic              RasEmpty,
  output logic              RasFull,
  output logic              RasUnderflow
);

  pc_src_e           src;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_has;
  logic              pc_en;
  logic              push;
  logic              pop;
  logic              uflow;
  logic              t_exc;
  logic              t_redir;
  logic              t_ret;

  assign pc_inc  = PCResult + ADDR_W'(INC);
  assign ras_has = (ras_cnt != '0);

  assign t_exc   = Exception;
  assign t_redir = !Exception && PCWrite && Redirect;
  assign t_ret   = !Exception && PCWrite && !Redirect
                   && Return && ras_has;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Push     (push),
    .Pop      (pop),
    .PushData (pc_inc),
    .Top      (ras_top),
    .Count    (ras_cnt),
    .Empty    (ras_empty),
    .Full     (ras_full)
  );

  assign RasEmpty = ras_empty;
  assign RasFull  = ras_full;

  // Next-PC source select and RAS control; exception beats everything.
  always_comb begin
    src   = SRC_SEQ;
    push  = 1'b0;
    pop   = 1'b0;
    uflow = 1'b0;
    pc_en = Exception || PCWrite;
    unique case (1'b1)
      t_exc: begin
        src = SRC_EXC;
      end
      t_redir: begin
        src  = SRC_REDIRECT;
        push = Call;
      end
      t_ret: begin
        src = SRC_RETURN;
        pop = 1'b1;
      end
      default: begin
        src   = SRC_SEQ;
        uflow = !Exception && PCWrite && !Redirect
                && Return && !ras_has;
      end
    endcase
  end

  // Next-PC data mux.
  always_comb begin
    pc_d = pc_inc;
    unique case (src)
      SRC_EXC:      pc_d = EXC_VEC;
      SRC_REDIRECT: pc_d = RedirectTarget;
      SRC_RETURN:   pc_d = ras_top;
      default:      pc_d = pc_inc;
    endcase
  end

  // PC, EPC and underflow pulse registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      PCResult     <= RESET_VEC;
      EPC          <= '0;
      RasUnderflow <= 1'b0;
    end else begin
      RasUnderflow <= uflow;
      if (pc_en)
        PCResult <= pc_d;
      if (Exception)
        EPC <= PCResult;
    end
  end

`ifdef PC_TRACE_EN
  // Simulation trace of post-update state.
  always @(posedge Clk) begin
    if (Reset_n) begin
      $strobe("PC=%h EPC=%h RAS=%0d", PCResult, EPC, ras_cnt);
      if (uflow)
        $strobe("RAS underflow");
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Expected values are hand-computed from default parameters.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        PCWrite;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Call;
  logic        Return;
  logic        Exception;
  logic [31:0] PCResult;
  logic [31:0] EPC;
  logic        RasEmpty;
  logic        RasFull;
  logic        RasUnderflow;

  int total;
  int bad;

  pc_sequencer dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .PCWrite        (PCWrite),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Call           (Call),
    .Return         (Return),
    .Exception      (Exception),
    .PCResult       (PCResult),
    .EPC            (EPC),
    .RasEmpty       (RasEmpty),
    .RasFull        (RasFull),
    .RasUnderflow   (RasUnderflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] t, input logic c);
    Redirect       = 1'b1;
    RedirectTarget = t;
    Call           = c;
    step();
    Redirect = 1'b0;
    Call     = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    Reset_n        = 1'b0;
    PCWrite        = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = '0;
    Call           = 1'b0;
    Return         = 1'b0;
    Exception      = 1'b0;
    #12;
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_epc", EPC, 32'h0);
    chk("rst_empty", 32'(RasEmpty), 32'd1);
    chk("rst_full", 32'(RasFull), 32'd0);
    chk("rst_uflow", 32'(RasUnderflow), 32'd0);
    Reset_n = 1'b1;

    // free run
    PCWrite = 1'b1;
    step(); chk("seq1", PCResult, 32'h4);
    step(); chk("seq2", PCResult, 32'h8);
    step(); chk("seq3", PCResult, 32'hC);
    chk("seq_empty", 32'(RasEmpty), 32'd1);
    step(); chk("seq4", PCResult, 32'h10);

    // stall with redirect pending
    PCWrite        = 1'b0;
    Redirect       = 1'b1;
    RedirectTarget = 32'h40;
    step(); chk("stall1", PCResult, 32'h10);
    step(); chk("stall2", PCResult, 32'h10);
    PCWrite = 1'b1;
    step(); chk("release", PCResult, 32'h40);
    Redirect = 1'b0;

    // call without redirect is ignored
    Call = 1'b1;
    step(); chk("callnr_pc", PCResult, 32'h44);
    chk("callnr_empty", 32'(RasEmpty), 32'd1);
    Call = 1'b0;

    // single call / return
    jump(32'h20, 1'b0);
    chk("to20", PCResult, 32'h20);
    jump(32'h100, 1'b1);
    chk("call_pc", PCResult, 32'h100);
    chk("call_empty", 32'(RasEmpty), 32'd0);
    step(); chk("run1", PCResult, 32'h104);
    step(); chk("run2", PCResult, 32'h108);
    Return = 1'b1;
    step(); chk("ret_pc", PCResult, 32'h24);
    chk("ret_empty", 32'(RasEmpty), 32'd1);
    Return = 1'b0;

    // nested calls, overflow then underflow
    jump(32'h0, 1'b0);
    chk("to0", PCResult, 32'h0);
    jump(32'h100, 1'b1);
    jump(32'h200, 1'b1);
    jump(32'h300, 1'b1);
    chk("n3_full", 32'(RasFull), 32'd0);
    jump(32'h400, 1'b1);
    chk("n4_full", 32'(RasFull), 32'd1);
    jump(32'h500, 1'b1);
    chk("n5_pc", PCResult, 32'h500);
    chk("n5_full", 32'(RasFull), 32'd1);
    Return = 1'b1;
    step(); chk("pop1", PCResult, 32'h404);
    chk("pop1_full", 32'(RasFull), 32'd0);
    step(); chk("pop2", PCResult, 32'h304);
    step(); chk("pop3", PCResult, 32'h204);
    chk("pop3_uf", 32'(RasUnderflow), 32'd0);
    step(); chk("pop4", PCResult, 32'h104);
    chk("pop4_empty", 32'(RasEmpty), 32'd1);
    step(); chk("pop5", PCResult, 32'h108);
    chk("pop5_uf", 32'(RasUnderflow), 32'd1);
    Return = 1'b0;
    step(); chk("after_pc", PCResult, 32'h10C);
    chk("after_uf", 32'(RasUnderflow), 32'd0);

    // stalled empty return makes no pulse
    PCWrite = 1'b0;
    Return  = 1'b1;
    step(); chk("stall_uf", 32'(RasUnderflow), 32'd0);
    chk("stall_pc", PCResult, 32'h10C);
    Return  = 1'b0;
    PCWrite = 1'b1;

    // wrap-around
    jump(32'hFFFF_FFFC, 1'b0);
    step(); chk("wrap", PCResult, 32'h0);

    // exception while stalled, redirect also up
    jump(32'h88, 1'b0);
    PCWrite        = 1'b0;
    Redirect       = 1'b1;
    RedirectTarget = 32'h40;
    Exception      = 1'b1;
    step();
    chk("exc_pc", PCResult, 32'h8000_0180);
    chk("exc_epc", EPC, 32'h88);
    Exception = 1'b0;
    Redirect  = 1'b0;
    PCWrite   = 1'b1;
    step(); chk("exc_next", PCResult, 32'h8000_0184);
    chk("exc_epc_hold", EPC, 32'h88);

    // async reset mid-cycle after two pushes
    jump(32'h600, 1'b1);
    jump(32'h700, 1'b1);
    chk("pre_rst_empty", 32'(RasEmpty), 32'd0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_pc", PCResult, 32'h0);
    chk("arst_empty", 32'(RasEmpty), 32'd1);
    chk("arst_full", 32'(RasFull), 32'd0);
    chk("arst_epc", EPC, 32'h0);
    step();
    Reset_n = 1'b1;
    step(); chk("post_rst", PCResult, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
